// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard controller: load-use, redirect, memory-wait freeze
module hazard_ctrl #(
    parameter int CNT_BITS = 32,
    parameter int REG_BITS = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [REG_BITS-1:0] id_rs1_addr,
    input  logic [REG_BITS-1:0] id_rs2_addr,
    input  logic                id_use_rs1,
    input  logic                id_use_rs2,
    input  logic [REG_BITS-1:0] ex_rd_addr,
    input  logic                ex_dm_rd,
    input  logic                ex_redirect,
    input  logic                im_wait,
    input  logic                dm_wait,
    output logic                pc_hold,
    output logic                if_id_hold,
    output logic                if_id_flush,
    output logic                id_stall,
    output logic                id_flush,
    output logic                pipe_freeze,
    output logic [CNT_BITS-1:0] stall_cnt,
    output logic [CNT_BITS-1:0] flush_cnt
);

    // WAIT_FLUSH remembers a redirect that arrived while the pipe was frozen
    localparam logic [1:0] S_RUN        = 2'd0;
    localparam logic [1:0] S_WAIT       = 2'd1;
    localparam logic [1:0] S_WAIT_FLUSH = 2'd2;

    logic [1:0]          r_state;
    logic [1:0]          w_next_state;
    logic [CNT_BITS-1:0] r_stall_cnt;
    logic [CNT_BITS-1:0] r_flush_cnt;

    logic w_load_use;
    logic w_mem_busy;
    logic w_pc_hold;
    logic w_if_id_hold;
    logic w_if_id_flush;
    logic w_id_stall;
    logic w_id_flush;
    logic w_pipe_freeze;

    // A load into x0 never creates a dependency
    assign w_load_use = ex_dm_rd && (ex_rd_addr != '0) &&
                        ((id_use_rs1 && (id_rs1_addr == ex_rd_addr)) ||
                         (id_use_rs2 && (id_rs2_addr == ex_rd_addr)));
    assign w_mem_busy = im_wait || dm_wait;

    // Hazard decode with fixed priority: memory wait, redirect (live or pending), load-use
    always_comb begin
        w_pc_hold     = 1'b0;
        w_if_id_hold  = 1'b0;
        w_if_id_flush = 1'b0;
        w_id_stall    = 1'b0;
        w_id_flush    = 1'b0;
        w_pipe_freeze = 1'b0;
        w_next_state  = r_state;
        case (r_state)
            S_RUN, S_WAIT: begin
                if (w_mem_busy) begin
                    w_pc_hold     = 1'b1;
                    w_if_id_hold  = 1'b1;
                    w_pipe_freeze = 1'b1;
                    w_next_state  = ex_redirect ? S_WAIT_FLUSH : S_WAIT;
                end else if (ex_redirect) begin
                    w_if_id_flush = 1'b1;
                    w_id_flush    = 1'b1;
                    w_next_state  = S_RUN;
                end else if (w_load_use) begin
                    w_pc_hold     = 1'b1;
                    w_if_id_hold  = 1'b1;
                    w_id_stall    = 1'b1;
                    w_next_state  = S_RUN;
                end else begin
                    w_next_state  = S_RUN;
                end
            end
            S_WAIT_FLUSH: begin
                if (w_mem_busy) begin
                    w_pc_hold     = 1'b1;
                    w_if_id_hold  = 1'b1;
                    w_pipe_freeze = 1'b1;
                end else begin
                    // Pending redirect is applied even if ex_redirect has dropped
                    w_if_id_flush = 1'b1;
                    w_id_flush    = 1'b1;
                    w_next_state  = S_RUN;
                end
            end
            default: w_next_state = S_RUN;
        endcase
        if (!rst_n) begin
            w_pc_hold     = 1'b0;
            w_if_id_hold  = 1'b0;
            w_if_id_flush = 1'b0;
            w_id_stall    = 1'b0;
            w_id_flush    = 1'b0;
            w_pipe_freeze = 1'b0;
            w_next_state  = S_RUN;
        end
    end

    // State register and saturating stall/flush performance counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_RUN;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_pc_hold && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_BITS'(1);
            end
            if (w_if_id_flush && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CNT_BITS'(1);
            end
        end
    end

    assign pc_hold     = w_pc_hold;
    assign if_id_hold  = w_if_id_hold;
    assign if_id_flush = w_if_id_flush;
    assign id_stall    = w_id_stall;
    assign id_flush    = w_id_flush;
    assign pipe_freeze = w_pipe_freeze;
    assign stall_cnt   = r_stall_cnt;
    assign flush_cnt   = r_flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - randomized self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

    localparam int CNT_BITS = 6;
    localparam int REG_BITS = 5;
    localparam int CNT_MAX  = (1 << CNT_BITS) - 1;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [REG_BITS-1:0] id_rs1_addr;
    logic [REG_BITS-1:0] id_rs2_addr;
    logic                id_use_rs1;
    logic                id_use_rs2;
    logic [REG_BITS-1:0] ex_rd_addr;
    logic                ex_dm_rd;
    logic                ex_redirect;
    logic                im_wait;
    logic                dm_wait;
    logic                pc_hold;
    logic                if_id_hold;
    logic                if_id_flush;
    logic                id_stall;
    logic                id_flush;
    logic                pipe_freeze;
    logic [CNT_BITS-1:0] stall_cnt;
    logic [CNT_BITS-1:0] flush_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: a pending-redirect flag and two integer counters
    bit m_pend = 1'b0;
    int m_stall = 0;
    int m_flush = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.CNT_BITS(CNT_BITS), .REG_BITS(REG_BITS)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rd_addr(ex_rd_addr), .ex_dm_rd(ex_dm_rd),
        .ex_redirect(ex_redirect), .im_wait(im_wait), .dm_wait(dm_wait),
        .pc_hold(pc_hold), .if_id_hold(if_id_hold), .if_id_flush(if_id_flush),
        .id_stall(id_stall), .id_flush(id_flush), .pipe_freeze(pipe_freeze),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input int rs1, input int rs2, input bit u1, input bit u2,
                         input int rd, input bit dmrd, input bit redir,
                         input bit imw, input bit dmw, input bit rstn);
        id_rs1_addr = REG_BITS'(rs1);
        id_rs2_addr = REG_BITS'(rs2);
        id_use_rs1  = u1;
        id_use_rs2  = u2;
        ex_rd_addr  = REG_BITS'(rd);
        ex_dm_rd    = dmrd;
        ex_redirect = redir;
        im_wait     = imw;
        dm_wait     = dmw;
        rst_n       = rstn;
    endtask

    // One cycle: compare controls and counters mid-cycle, then advance the model
    task automatic step(input string tag);
        bit busy, lu, e_hold, e_flush, e_stall;
        logic [5:0] exp_ctl, got_ctl;
        #4;
        busy = im_wait | dm_wait;
        lu = ex_dm_rd && (ex_rd_addr != 0) &&
             ((id_use_rs1 && id_rs1_addr == ex_rd_addr) ||
              (id_use_rs2 && id_rs2_addr == ex_rd_addr));
        e_hold = 0; e_flush = 0; e_stall = 0;
        exp_ctl = '0;
        if (rst_n) begin
            if (busy) begin
                exp_ctl = 6'b110001;
                e_hold = 1;
            end else if (ex_redirect || m_pend) begin
                exp_ctl = 6'b001010;
                e_flush = 1;
            end else if (lu) begin
                exp_ctl = 6'b110100;
                e_hold = 1;
                e_stall = 1;
            end
        end
        got_ctl = {pc_hold, if_id_hold, if_id_flush, id_stall, id_flush, pipe_freeze};
        check({tag, ".ctl"}, 32'(got_ctl), 32'(exp_ctl));
        check({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(m_stall));
        check({tag, ".flush_cnt"}, 32'(flush_cnt), 32'(m_flush));
        check({tag, ".stall_and_flush"}, 32'(id_stall & id_flush), 32'd0);
        check({tag, ".hold_and_ifflush"}, 32'(pc_hold & if_id_flush), 32'd0);
        if (!rst_n) begin
            m_pend = 0; m_stall = 0; m_flush = 0;
        end else begin
            if (e_hold && m_stall < CNT_MAX) m_stall++;
            if (e_flush && m_flush < CNT_MAX) m_flush++;
            m_pend = busy ? (m_pend | ex_redirect) : 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string tag);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(tag);
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("reset");
        step("reset");
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        do_reset();
        check("reset.stall_cnt", 32'(stall_cnt), 32'd0);
        check("reset.flush_cnt", 32'(flush_cnt), 32'd0);

        // Load-use on rs1: one bubble then clear
        drive(5, 0, 1, 0, 5, 1, 0, 0, 0, 1);
        step("lu_rs1");
        idle("lu_rs1_after");
        check("lu_rs1.stall_cnt", 32'(stall_cnt), 32'd1);

        // Load into x0, and unused rs2 with matching address: no stall
        drive(0, 0, 0, 1, 0, 1, 0, 0, 0, 1);
        step("lu_x0");
        drive(0, 5, 0, 0, 5, 1, 0, 0, 0, 1);
        step("lu_rs2_unused");
        check("no_stall.stall_cnt", 32'(stall_cnt), 32'd1);

        // Taken branch pulse
        do_reset();
        drive(0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
        step("branch");
        idle("branch_after");
        check("branch.flush_cnt", 32'(flush_cnt), 32'd1);

        // Redirect during a 4-cycle data-memory freeze
        do_reset();
        drive(0, 0, 0, 0, 0, 0, 1, 0, 1, 1);
        step("freeze_c1");
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
            step("freeze");
        end
        idle("freeze_flush");
        idle("freeze_after");
        check("freeze.flush_cnt", 32'(flush_cnt), 32'd1);
        check("freeze.stall_cnt", 32'(stall_cnt), 32'd4);

        // Simultaneous redirect and load-use, memory idle
        do_reset();
        drive(7, 0, 1, 0, 7, 1, 1, 0, 0, 1);
        step("redir_lu");
        check("redir_lu.stall_cnt", 32'(stall_cnt), 32'd0);
        check("redir_lu.flush_cnt", 32'(flush_cnt), 32'd1);

        // Reset while a redirect is pending discards it
        drive(0, 0, 0, 0, 0, 0, 1, 1, 0, 1);
        step("wf_enter");
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        step("wf_reset");
        idle("wf_after_reset");
        check("wf_reset.flush_cnt", 32'(flush_cnt), 32'd0);
        check("wf_reset.stall_cnt", 32'(stall_cnt), 32'd0);

        // Randomized traffic, long enough to reach counter saturation
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 1), $urandom_range(0, 1),
                  $urandom_range(0, 3), $urandom_range(0, 1),
                  ($urandom_range(0, 5) == 0), ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 4) == 0), ($urandom_range(0, 499) != 0));
            step("rand");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
